sci_sequencer: RTL and testbench



---
 rtl/sci_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_sci_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sci_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the SCI datapath.
// Drives a small register file through registered addr/rw/wdata and runs an 8-bit ALU op set.
module sci_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int PC_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [15:0]              instr,
  output logic [PC_WIDTH-1:0]      pc,
  input  logic [DATA_WIDTH-1:0]    rf_out,
  output logic [RF_ADDR_WIDTH-1:0] rf_addr,
  output logic                     rf_rw,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic                     zero,
  output logic                     carry,
  output logic                     halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t                   state_q,    state_d;
  logic [PC_WIDTH-1:0]      pc_q,       pc_d;
  logic [15:0]              ir_q,       ir_d;
  logic [DATA_WIDTH-1:0]    opa_q,      opa_d;
  logic [DATA_WIDTH-1:0]    opb_q,      opb_d;
  logic                     zero_q,     zero_d;
  logic                     carry_q,    carry_d;
  logic                     halted_q,   halted_d;
  logic                     rf_rw_q,    rf_rw_d;
  logic [RF_ADDR_WIDTH-1:0] rf_addr_q,  rf_addr_d;
  logic [DATA_WIDTH-1:0]    rf_wdata_q, rf_wdata_d;

  logic [3:0]            op;
  logic [1:0]            rd;
  logic [1:0]            rs;
  logic [7:0]            imm;
  logic [DATA_WIDTH:0]   alu_res;

  // Register selectors are 2 bits wide; the upper address bits stay zero.
  function automatic logic [RF_ADDR_WIDTH-1:0] sel_addr(input logic [1:0] sel);
    return RF_ADDR_WIDTH'(sel);
  endfunction

  // Returns {carry, result}; for SUB the extra bit of the widened difference is the borrow.
  function automatic logic [DATA_WIDTH:0] alu(input logic [3:0]            f,
                                              input logic [DATA_WIDTH-1:0] a,
                                              input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] r;
    case (f)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  assign op      = ir_q[15:12];
  assign rd      = ir_q[11:10];
  assign rs      = ir_q[9:8];
  assign imm     = ir_q[7:0];
  assign alu_res = alu(op, opa_q, opb_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    halted_d   = halted_q;
    rf_rw_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;

    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = instr;
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_JMP: begin
            pc_d    = PC_WIDTH'(imm);
            state_d = S_FETCH;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          OP_LDI: begin
            rf_wdata_d = DATA_WIDTH'(imm);
            rf_addr_d  = sel_addr(rd);
            rf_rw_d    = 1'b1;
            state_d    = S_WB;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_JZ: begin
            rf_addr_d = sel_addr(rs);
            state_d   = S_RD_A;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_RD_A: begin
        opb_d = rf_out;
        if (op == OP_MOV) begin
          rf_addr_d  = sel_addr(rd);
          rf_wdata_d = rf_out;
          rf_rw_d    = 1'b1;
          state_d    = S_WB;
        end else if (op == OP_JZ) begin
          state_d = S_EXEC;
        end else begin
          rf_addr_d = sel_addr(rd);
          state_d   = S_RD_B;
        end
      end
      S_RD_B: begin
        opa_d   = rf_out;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op == OP_JZ) begin
          if (opb_q == '0) pc_d = PC_WIDTH'(imm);
          state_d = S_FETCH;
        end else begin
          rf_wdata_d = alu_res[DATA_WIDTH-1:0];
          rf_addr_d  = sel_addr(rd);
          zero_d     = (alu_res[DATA_WIDTH-1:0] == '0);
          carry_d    = alu_res[DATA_WIDTH];
          rf_rw_d    = 1'b1;
          state_d    = S_WB;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT: begin
        halted_d = 1'b1;
        state_d  = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Async reset also drops rf_rw at once, so an interrupted write never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      halted_q   <= 1'b0;
      rf_rw_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      halted_q   <= halted_d;
      rf_rw_q    <= rf_rw_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign pc       = pc_q;
  assign rf_addr  = rf_addr_q;
  assign rf_rw    = rf_rw_q;
  assign rf_wdata = rf_wdata_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_sci_sequencer.sv
// Bench for sci_sequencer: ROM + 4-entry register file around the DUT, directed vector table,
// hand-written corner sequences and random programs checked against an instruction-level model.
module tb_sci_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic [7:0]  rf_out;
  logic [4:0]  rf_addr;
  logic        rf_rw;
  logic [7:0]  rf_wdata;
  logic        zero;
  logic        carry;
  logic        halted;

  sci_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .pc(pc),
    .rf_out(rf_out), .rf_addr(rf_addr), .rf_rw(rf_rw), .rf_wdata(rf_wdata),
    .zero(zero), .carry(carry), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  logic [7:0]  rf [4];
  logic        rf_clear;
  int          cyc_cnt = 0;
  int          wr_total = 0;
  int          wr_cyc = 0;
  int          addr_hi_bad = 0;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;

  assign instr  = rom[pc];
  assign rf_out = rf[rf_addr[1:0]];

  // Register file plus a write monitor (absolute cycle index of the last write).
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (rf_clear) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else if (rf_rw) begin
      rf[rf_addr[1:0]] <= rf_wdata;
    end
    if (rf_rw) begin
      wr_total <= wr_total + 1;
      wr_cyc   <= cyc_cnt + 1;
      wr_addr  <= rf_addr;
      wr_data  <= rf_wdata;
      if (rf_addr[4:2] != 3'b000) addr_hi_bad <= addr_hi_bad + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; rf_clear = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; rf_clear = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'h0);
    chk({tag, "_flags"}, 32'({zero, carry}), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_rf_rw"}, 32'(rf_rw), 32'h0);
    chk({tag, "_rf_addr"}, 32'(rf_addr), 32'h0);
    chk({tag, "_rf_wdata"}, 32'(rf_wdata), 32'h0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] ins;
    int          cyc;
    logic        wr;
    logic [1:0]  wa;
    logic [7:0]  wd;
    logic [7:0]  pc_nxt;
    logic        z;
    logic        c;
  } vec_t;

  vec_t tbl [17];

  // Instruction-level reference model.
  logic [7:0] m_pc;
  logic [7:0] m_r [4];
  logic       m_z;
  logic       m_c;

  task automatic model_step(input logic [15:0] ins, output int cyc, output logic wr,
                            output logic [1:0] wa, output logic [7:0] wd);
    int a, b, s;
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm;
    op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
    m_pc = m_pc + 8'd1;
    wr = 1'b0; wa = rd; wd = 8'h00; cyc = 2;
    a = int'(m_r[rd]); b = int'(m_r[rs]);
    case (op)
      4'h1: begin cyc = 3; wr = 1'b1; wd = imm; end
      4'h2, 4'h3, 4'h4, 4'h5: begin
        cyc = 6; wr = 1'b1;
        if (op == 4'h2) begin s = a + b; m_c = (s > 255); s = s % 256; end
        else if (op == 4'h3) begin m_c = (a < b); s = (a - b + 256) % 256; end
        else if (op == 4'h4) begin m_c = 1'b0; s = a & b; end
        else begin m_c = 1'b0; s = a | b; end
        wd = 8'(s);
        m_z = (s == 0);
      end
      4'h6: begin cyc = 4; wr = 1'b1; wd = m_r[rs]; end
      4'h7: begin cyc = 4; if (m_r[rs] == 8'h00) m_pc = imm; end
      4'h8: m_pc = imm;
      default: ;
    endcase
    if (wr) m_r[rd] = wd;
  endtask

  initial begin
    int bw, bc, cyc;
    logic wr;
    logic [1:0] wa;
    logic [7:0] wd;

    rst = 1'b1; run = 1'b0; rf_clear = 1'b1;
    clear_rom();

    tbl[0]  = '{8'h00, 16'h10F0, 3, 1'b1, 2'd0, 8'hF0, 8'h01, 1'b0, 1'b0};
    tbl[1]  = '{8'h01, 16'h1420, 3, 1'b1, 2'd1, 8'h20, 8'h02, 1'b0, 1'b0};
    tbl[2]  = '{8'h02, 16'h2100, 6, 1'b1, 2'd0, 8'h10, 8'h03, 1'b0, 1'b1};
    tbl[3]  = '{8'h03, 16'h3500, 6, 1'b1, 2'd1, 8'h00, 8'h04, 1'b1, 1'b0};
    tbl[4]  = '{8'h04, 16'h1403, 3, 1'b1, 2'd1, 8'h03, 8'h05, 1'b1, 1'b0};
    tbl[5]  = '{8'h05, 16'h1005, 3, 1'b1, 2'd0, 8'h05, 8'h06, 1'b1, 1'b0};
    tbl[6]  = '{8'h06, 16'h3400, 6, 1'b1, 2'd1, 8'hFE, 8'h07, 1'b0, 1'b1};
    tbl[7]  = '{8'h07, 16'h6D00, 4, 1'b1, 2'd3, 8'hFE, 8'h08, 1'b0, 1'b1};
    tbl[8]  = '{8'h08, 16'h7240, 4, 1'b0, 2'd0, 8'h00, 8'h40, 1'b0, 1'b1};
    tbl[9]  = '{8'h40, 16'h1801, 3, 1'b1, 2'd2, 8'h01, 8'h41, 1'b0, 1'b1};
    tbl[10] = '{8'h41, 16'h7240, 4, 1'b0, 2'd0, 8'h00, 8'h42, 1'b0, 1'b1};
    tbl[11] = '{8'h42, 16'h4C00, 6, 1'b1, 2'd3, 8'h04, 8'h43, 1'b0, 1'b0};
    tbl[12] = '{8'h43, 16'h5900, 6, 1'b1, 2'd2, 8'hFF, 8'h44, 1'b0, 1'b0};
    tbl[13] = '{8'h44, 16'h2500, 6, 1'b1, 2'd1, 8'hFC, 8'h45, 1'b0, 1'b1};
    tbl[14] = '{8'h45, 16'hE5A5, 2, 1'b0, 2'd0, 8'h00, 8'h46, 1'b0, 1'b1};
    tbl[15] = '{8'h46, 16'h80FF, 2, 1'b0, 2'd0, 8'h00, 8'hFF, 1'b0, 1'b1};
    tbl[16] = '{8'hFF, 16'h0000, 2, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1};

    // LDI then HALT: write in cycle 3, halted after cycle 5, pc frozen.
    rom[0] = 16'h187F; rom[1] = 16'hF000;
    do_reset();
    check_reset_state("rst0");
    run = 1'b1;
    bc = cyc_cnt; bw = wr_total;
    repeat (5) @(negedge clk);
    chk("halt_wr_cnt", 32'(wr_total - bw), 32'd1);
    chk("halt_wr_cyc", 32'(wr_cyc - bc), 32'd3);
    chk("halt_wr_addr", 32'(wr_addr), 32'd2);
    chk("halt_wr_data", 32'(wr_data), 32'h7F);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'd2);
    repeat (10) @(negedge clk);
    chk("halt_pc_frozen", 32'(pc), 32'd2);
    chk("halt_no_more_wr", 32'(wr_total - bw), 32'd1);
    chk("halt_stays", 32'(halted), 32'd1);

    // Directed vector table.
    clear_rom();
    foreach (tbl[i]) rom[tbl[i].addr] = tbl[i].ins;
    do_reset();
    check_reset_state("rst1");
    run = 1'b1;
    foreach (tbl[i]) begin
      bc = cyc_cnt; bw = wr_total;
      repeat (tbl[i].cyc) @(negedge clk);
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(tbl[i].pc_nxt));
      chk($sformatf("vec%0d_zc", i), 32'({zero, carry}), 32'({tbl[i].z, tbl[i].c}));
      chk($sformatf("vec%0d_wr_cnt", i), 32'(wr_total - bw), 32'(tbl[i].wr));
      if (tbl[i].wr) begin
        chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].wa));
        chk($sformatf("vec%0d_wr_data", i), 32'(wr_data), 32'(tbl[i].wd));
        chk($sformatf("vec%0d_wr_cyc", i), 32'(wr_cyc - bc), 32'(tbl[i].cyc));
      end
    end

    // Reset asserted during the WB cycle of an ADD.
    clear_rom();
    rom[0] = 16'h10F0; rom[1] = 16'h1420; rom[2] = 16'h2100;
    do_reset();
    run = 1'b1;
    repeat (11) @(negedge clk);
    chk("wb_reached", 32'(rf_rw), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_state("rst_wb");
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    bw = wr_total;
    repeat (10) @(negedge clk);
    chk("idle_no_wr", 32'(wr_total - bw), 32'd0);
    chk("idle_pc", 32'(pc), 32'd0);
    chk("rst_wb_r0_kept", 32'(rf[0]), 32'hF0);

    // run dropped mid-ADD: the ADD completes, then the sequencer stalls in FETCH.
    clear_rom();
    rom[0] = 16'h1005; rom[1] = 16'h1403; rom[2] = 16'h2100;
    do_reset();
    run = 1'b1;
    repeat (8) @(negedge clk);
    run = 1'b0;
    bw = wr_total;
    repeat (12) @(negedge clk);
    chk("stall_wr_cnt", 32'(wr_total - bw), 32'd1);
    chk("stall_wr_data", 32'(wr_data), 32'h08);
    chk("stall_pc", 32'(pc), 32'd3);

    // Random programs against the instruction-level model.
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 256; i++) rom[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
      do_reset();
      m_pc = 8'h00; m_z = 1'b0; m_c = 1'b0;
      for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
      run = 1'b1;
      for (int n = 0; n < 100; n++) begin
        model_step(rom[m_pc], cyc, wr, wa, wd);
        bw = wr_total;
        repeat (cyc) @(negedge clk);
        chk($sformatf("rnd%0d_%0d_pc", round, n), 32'(pc), 32'(m_pc));
        chk($sformatf("rnd%0d_%0d_zc", round, n), 32'({zero, carry}), 32'({m_z, m_c}));
        chk($sformatf("rnd%0d_%0d_wr_cnt", round, n), 32'(wr_total - bw), 32'(wr));
        if (wr) chk($sformatf("rnd%0d_%0d_rf", round, n), 32'(rf[wa]), 32'(wd));
      end
      chk($sformatf("rnd%0d_not_halted", round), 32'(halted), 32'd0);
    end

    chk("rf_addr_upper_zero", 32'(addr_hi_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
